// File: rtl/div_mod_if.sv
// div_mod_if -- request/result bundle for the div_mod sequential divider.
//
// Request side : i_valid, o_ready, i_dividend, i_divisor, i_signed
// Result side  : o_valid, i_ready, o_quot, o_rem, o_div_zero
//
// Modports:
//   slave  -- the divider (drives o_* signals)
//   master -- the requester/consumer (drives i_* signals)
interface div_mod_if #(
    parameter int WIDTH = 64
) ();
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             i_signed;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quot;
    logic [WIDTH-1:0] o_rem;
    logic             o_div_zero;

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_signed, i_ready,
        output o_ready, o_valid, o_quot, o_rem, o_div_zero
    );

    modport master (
        output i_valid, i_dividend, i_divisor, i_signed, i_ready,
        input  o_ready, o_valid, o_quot, o_rem, o_div_zero
    );
endinterface

// File: rtl/div_mod.sv
// div_mod -- sequential radix-2 restoring divider (IDLE -> CALC -> DONE).
//
// Ports:
//   i_clk    -- clock, all state changes on its rising edge
//   i_rst_n  -- asynchronous active-low reset
//   bus      -- div_mod_if.slave: valid/ready request with dividend, divisor
//               and i_signed; valid/ready result with o_quot, o_rem and
//               o_div_zero
//
// One quotient bit is resolved per CALC cycle, MSB first, for WIDTH cycles.
// A zero divisor bypasses CALC: quotient all ones, remainder = dividend,
// o_div_zero set.
//
// Configuration macro:
//   DIV_MOD_SIGNED_EN -- when defined, i_signed selects two's-complement
//                        operands (truncating quotient, remainder takes the
//                        dividend's sign). When undefined, i_signed is ignored
//                        and every operation is unsigned.
module div_mod #(
    parameter int WIDTH = 64
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    div_mod_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic             ready;
    logic             valid;
    logic             accept;
    logic             last;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dq;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem;       // partial remainder (always < divisor)
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             div_zero_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero_in;

    logic [WIDTH:0]   shifted;   // one guard bit above the remainder
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dq_step;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;

    assign div_zero_in = (bus.i_divisor == '0);
    assign last        = (cnt == '0);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        valid    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.i_valid) begin
                    accept   = 1'b1;
                    state_nx = div_zero_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (bus.i_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid;
    assign bus.o_quot     = quot_r;
    assign bus.o_rem      = rem_r;
    assign bus.o_div_zero = div_zero_r;

    // ---------------- operand preparation ----------------
`ifdef DIV_MOD_SIGNED_EN
    always_comb begin
        a_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
        b_neg = bus.i_signed & bus.i_divisor[WIDTH-1];
        a_mag = a_neg ? -bus.i_dividend : bus.i_dividend;
        b_mag = b_neg ? -bus.i_divisor  : bus.i_divisor;
    end
`else
    logic unused_signed;
    assign unused_signed = bus.i_signed;
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        a_mag = bus.i_dividend;
        b_mag = bus.i_divisor;
    end
`endif

    // ---------------- one restoring step ----------------
    always_comb begin
        shifted  = {rem, dq[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        q_bit    = ~diff[WIDTH];
        rem_step = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dq_step  = {dq[WIDTH-2:0], q_bit};
    end

    // Sign correction is folded into the final step so the corrected
    // result lands in the output registers on the edge that enters DONE.
`ifdef DIV_MOD_SIGNED_EN
    always_comb begin
        quot_fin = neg_q ? -dq_step  : dq_step;
        rem_fin  = neg_r ? -rem_step : rem_step;
    end
`else
    always_comb begin
        quot_fin = dq_step;
        rem_fin  = rem_step;
    end
`endif

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            dq         <= '0;
            rem        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            quot_r     <= '0;
            rem_r      <= '0;
            div_zero_r <= 1'b0;
        end else if (accept) begin
            cnt        <= CW'(WIDTH - 1);
            dq         <= a_mag;
            rem        <= '0;
            dvs        <= b_mag;
            neg_q      <= a_neg ^ b_neg;
            neg_r      <= a_neg;
            div_zero_r <= div_zero_in;
            if (div_zero_in) begin
                quot_r <= '1;
                rem_r  <= bus.i_dividend;
            end
        end else if (state == CALC) begin
            dq  <= dq_step;
            rem <= rem_step;
            cnt <= cnt - CW'(1);
            if (last) begin
                quot_r <= quot_fin;
                rem_r  <= rem_fin;
            end
        end
    end
endmodule

// File: tb/tb_div_mod.sv
module tb_div_mod;
`ifdef DIV_MOD_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad = 0;

    logic        sel64 = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_ready = 1'b0;
    logic        drv_signed = 1'b0;
    logic [63:0] drv_a = '0;
    logic [63:0] drv_b = '0;

    div_mod_if #(.WIDTH(8))  bus8 ();
    div_mod_if #(.WIDTH(64)) bus64 ();

    div_mod #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8.slave));
    div_mod #(.WIDTH(64)) dut64 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus64.slave));

    assign bus8.i_valid     = drv_valid & ~sel64;
    assign bus8.i_ready     = drv_ready & ~sel64;
    assign bus8.i_dividend  = drv_a[7:0];
    assign bus8.i_divisor   = drv_b[7:0];
    assign bus8.i_signed    = drv_signed;
    assign bus64.i_valid    = drv_valid & sel64;
    assign bus64.i_ready    = drv_ready & sel64;
    assign bus64.i_dividend = drv_a;
    assign bus64.i_divisor  = drv_b;
    assign bus64.i_signed   = drv_signed;

    logic        obs_valid, obs_ready, obs_z;
    logic [63:0] obs_q, obs_r;
    assign obs_valid = sel64 ? bus64.o_valid    : bus8.o_valid;
    assign obs_ready = sel64 ? bus64.o_ready    : bus8.o_ready;
    assign obs_z     = sel64 ? bus64.o_div_zero : bus8.o_div_zero;
    assign obs_q     = sel64 ? bus64.o_quot     : {56'd0, bus8.o_quot};
    assign obs_r     = sel64 ? bus64.o_rem      : {56'd0, bus8.o_rem};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division on w-bit operands.
    function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input bit sgn, output logic [63:0] q, output logic [63:0] r,
                                  output bit z);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        longint sa;
        longint sb;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        z = (b == 64'd0);
        if (z) begin
            q = mask;
            r = a;
        end else if (SIGNED_EN && sgn) begin
            sa = longint'(a << (64 - w)) >>> (64 - w);
            sb = longint'(b << (64 - w)) >>> (64 - w);
            if (sb == -1) begin
                q = (-a) & mask;
                r = 64'd0;
            end else begin
                q = 64'(sa / sb) & mask;
                r = 64'(sa % sb) & mask;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // One full transaction: accept, latency, result, optional backpressure, handshake.
    task automatic run_op(input bit big, input logic [63:0] a, input logic [63:0] b,
                          input bit sgn, input int hold, input bit keep_valid);
        int w;
        int lat;
        logic [63:0] eq;
        logic [63:0] er;
        bit ez;
        w = big ? 64 : 8;
        model(w, a, b, sgn, eq, er, ez);
        sel64 = big;
        drv_a = a;
        drv_b = b;
        drv_signed = sgn;
        drv_valid = 1'b1;
        drv_ready = 1'b0;
        #1;
        check("ready_idle", 64'(obs_ready), 64'd1);
        tick();
        if (!keep_valid) drv_valid = 1'b0;
        lat = 1;
        while (!obs_valid && lat < 2 * w + 10) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), ez ? 64'd1 : 64'(w + 1));
        check("quot", obs_q, eq);
        check("rem", obs_r, er);
        check("div_zero", 64'(obs_z), 64'(ez));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 64'(obs_valid), 64'd1);
            check("hold_ready", 64'(obs_ready), 64'd0);
            check("hold_quot", obs_q, eq);
            check("hold_rem", obs_r, er);
            check("hold_dz", 64'(obs_z), 64'(ez));
        end
        drv_ready = 1'b1;
        tick();
        check("post_valid", 64'(obs_valid), 64'd0);
        check("post_ready", 64'(obs_ready), 64'd1);
        drv_valid = 1'b0;
        drv_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(obs_ready), 64'd1);
        check({tag, "_valid"}, 64'(obs_valid), 64'd0);
        check({tag, "_quot"}, obs_q, 64'd0);
        check({tag, "_rem"}, obs_r, 64'd0);
        check({tag, "_dz"}, 64'(obs_z), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        #1 rst_n = 1'b0;
        #1;
        sel64 = 1'b0;
        #1 check_reset_outputs("rst8");
        sel64 = 1'b1;
        #1 check_reset_outputs("rst64");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors
        run_op(1'b1, 64'd100, 64'd7, 1'b0, 0, 1'b0);
        run_op(1'b0, 64'hF9, 64'h02, 1'b1, 0, 1'b0);
        run_op(1'b0, 64'h05, 64'h00, 1'b0, 0, 1'b0);
        run_op(1'b0, 64'h80, 64'hFF, 1'b1, 0, 1'b0);
        run_op(1'b0, 64'hF9, 64'h00, 1'b1, 0, 1'b0);
        run_op(1'b0, 64'hFF, 64'h01, 1'b0, 0, 1'b0);
        // Backpressure with i_valid held high through DONE and the handshake
        run_op(1'b0, 64'hC8, 64'h0D, 1'b1, 3, 1'b1);

        // Randomized 8-bit
        for (int i = 0; i < 40; i++) begin
            a = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) a = 64'h80;
            case ($urandom_range(0, 5))
                0:       b = 64'h00;
                1:       b = 64'hFF;
                2:       b = 64'h01;
                default: b = 64'($urandom_range(0, 255));
            endcase
            run_op(1'b0, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)));
        end

        // Randomized 64-bit
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            run_op(1'b1, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'b0);
        end

        // Reset 10 cycles into CALC, then a fresh request
        sel64 = 1'b1;
        drv_a = 64'd12345;
        drv_b = 64'd7;
        drv_signed = 1'b0;
        drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midcalc_rst");
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale_valid", 64'(obs_valid), 64'd0);
        end
        run_op(1'b1, 64'd9, 64'd3, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
